// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default sizes,
// FSM state encodings and the saturating statistics helper.
package mult_share_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DW      = 4;
  localparam int DEF_LAT     = 3;
  localparam int TAG_VLD_W   = 1;
  localparam int STAT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches req from ptr upward, wrapping,
// and returns a one-hot grant plus the encoded winner id.
module rr_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     gnt_id
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin issue
// and a tag pipe for result routing. Optional per-requester grant counters: MULT_ARB_STATS_EN.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW      = DEF_DW,
  parameter int LAT     = DEF_LAT,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_x,
  input  logic [NUM_REQ*DW-1:0] req_y,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         mul_x,
  output logic [DW-1:0]         mul_y,
  input  logic [2*DW-1:0]       mul_out,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*DW-1:0]       rsp_data,
  output logic                  idle
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

  arb_state_e state_q, state_d;
  logic                              idle_q, idle_d;
  logic [IDW-1:0]                    ptr_q, ptr_d;
  logic [DW-1:0]                     mul_x_q, mul_x_d;
  logic [DW-1:0]                     mul_y_q, mul_y_d;
  logic [LAT:0][TAG_VLD_W-1:0]       tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0]             tag_id_q, tag_id_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]                    rsp_id_q, rsp_id_d;
  logic [2*DW-1:0]                   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_id;
  logic               grant_en;
  logic               accept;
  logic               pipe_busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // Grants are suppressed while draining, including the cycle that re-enters RUN.
  assign grant_en  = arb_en && (state_q != ST_DRAIN);
  assign req_ready = grant & {NUM_REQ{grant_en}};
  assign accept    = |req_ready;
  assign pipe_busy = |tag_vld_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_en) state_d = ST_RUN;
      ST_RUN:   if (!arb_en) state_d = pipe_busy ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (arb_en)          state_d = ST_RUN;
        else if (!pipe_busy) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_comb begin
    ptr_d   = ptr_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    if (accept) begin
      ptr_d = (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_x_d = req_x[i*DW +: DW];
        mul_y_d = req_y[i*DW +: DW];
      end
    end
  end

  // Tag entry LAT lines up with mul_out, so the response stage samples both together.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = accept;
    tag_id_d[0]  = gnt_id;
    for (int i = 1; i <= LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    rsp_valid_d = tag_vld_q[LAT][0];
    rsp_id_d    = tag_vld_q[LAT][0] ? tag_id_q[LAT] : rsp_id_q;
    rsp_data_d  = tag_vld_q[LAT][0] ? mul_out       : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idle_q      <= 1'b1;
      ptr_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      ptr_q       <= ptr_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = idle_q;

`ifdef MULT_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) stat_d[i] = sat_inc(stat_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed scoreboard bench for mult_share_arbiter with a 3-stage multiplier model.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 4;
  localparam int LAT     = 3;
  localparam int IDW     = 2;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [2*DW-1:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  arb_en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [DW-1:0]         x_arr [NUM_REQ];
  logic [DW-1:0]         y_arr [NUM_REQ];
  logic [NUM_REQ*DW-1:0] req_x, req_y;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DW-1:0]         mul_x, mul_y;
  logic [2*DW-1:0]       mul_out;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*DW-1:0]       rsp_data;
  logic                  idle;
`ifdef MULT_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_cnt;
`endif

  logic [2*DW-1:0] m1, m2, m3;
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;
  int   rsp_mark;

  always #5 clk = ~clk;

  assign req_x = {x_arr[3], x_arr[2], x_arr[1], x_arr[0]};
  assign req_y = {y_arr[3], y_arr[2], y_arr[1], y_arr[0]};

  // Pipelined multiplier: product appears LAT edges after the operands are registered.
  always_ff @(posedge clk) begin
    m1 <= {4'b0, mul_x} * {4'b0, mul_y};
    m2 <= m1;
    m3 <= m2;
  end
  assign mul_out = m3;

  mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DW      (DW),
    .LAT     (LAT),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .idle      (idle)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check grant, push expected products, score any response.
  task automatic cycle(input logic [NUM_REQ-1:0] exp_ready);
    exp_t e;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ready[i] && req_valid[i])
        sb.push_back('{id: IDW'(i), data: {4'b0, x_arr[i]} * {4'b0, y_arr[i]}});
    end
    if (rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mul_x"},     32'(mul_x),     32'd0);
    check({tag, "_mul_y"},     32'(mul_y),     32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_idle"},      32'(idle),      32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      x_arr[i] = '0;
      y_arr[i] = '0;
    end

    apply_reset();
    check_reset_outputs("reset");
    check("reset_ready", 32'(req_ready), 32'd0);

    // Test 1: single request, exact latency, idle returns.
    arb_en    = 1'b1;
    req_valid = 4'b0001;
    x_arr[0]  = 4'd3;
    y_arr[0]  = 4'd2;
    cycle(4'b0001);
    req_valid = '0;
    arb_en    = 1'b0;
    check("t1_busy", 32'(idle), 32'd0);
    repeat (4) cycle(4'b0000);
    check("t1_no_early_rsp", 32'(n_rsp), 32'd0);
    cycle(4'b0000);
    check("t1_latency", 32'(n_rsp), 32'd1);
    repeat (3) cycle(4'b0000);
    check("t1_idle", 32'(idle), 32'd1);
    check("t1_data_hold", 32'(rsp_data), 32'd6);

    // Test 2: all requesters valid, strict round-robin from pointer 0.
    apply_reset();
    arb_en    = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      x_arr[i] = DW'(i + 5);
      y_arr[i] = 4'd2;
    end
    rsp_mark = n_rsp;
    repeat (2) begin
      cycle(4'b0001);
      cycle(4'b0010);
      cycle(4'b0100);
      cycle(4'b1000);
    end
    req_valid = '0;
    repeat (6) cycle(4'b0000);
    check("t2_rsp_count", 32'(n_rsp - rsp_mark), 32'd8);

    // Test 3: lone requester is granted every cycle.
    req_valid = 4'b0010;
    x_arr[1]  = 4'd15;
    y_arr[1]  = 4'd15;
    rsp_mark  = n_rsp;
    repeat (5) cycle(4'b0010);
    req_valid = '0;
    repeat (6) cycle(4'b0000);
    check("t3_rsp_count", 32'(n_rsp - rsp_mark), 32'd5);
    arb_en = 1'b0;
    repeat (2) cycle(4'b0000);
    check("t3_idle", 32'(idle), 32'd1);

    // Test 4: drop arb_en after two issues; pipe drains then FSM idles.
    arb_en    = 1'b1;
    req_valid = 4'b0101;
    x_arr[0]  = 4'd1;  y_arr[0] = 4'd4;
    x_arr[2]  = 4'd2;  y_arr[2] = 4'd3;
    rsp_mark  = n_rsp;
    cycle(4'b0100);
    cycle(4'b0001);
    arb_en = 1'b0;
    cycle(4'b0000);
    check("t4_draining", 32'(idle), 32'd0);
    repeat (7) cycle(4'b0000);
    check("t4_rsp_count", 32'(n_rsp - rsp_mark), 32'd2);
    check("t4_idle", 32'(idle), 32'd1);

    // Test 4b: re-enable during DRAIN gives no grant in the transition cycle.
    req_valid = 4'b0001;
    arb_en    = 1'b1;
    rsp_mark  = n_rsp;
    cycle(4'b0001);
    arb_en = 1'b0;
    cycle(4'b0000);
    arb_en = 1'b1;
    cycle(4'b0000);
    cycle(4'b0001);
    req_valid = '0;
    repeat (6) cycle(4'b0000);
    check("t4b_rsp_count", 32'(n_rsp - rsp_mark), 32'd2);
    arb_en = 1'b0;
    repeat (2) cycle(4'b0000);

    // Test 5: asynchronous reset with three products in flight.
    arb_en    = 1'b1;
    req_valid = 4'b1111;
    cycle(4'b0010);
    cycle(4'b0100);
    cycle(4'b1000);
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = '0;
    #1;
    check_reset_outputs("t5_async");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rsp_mark = n_rsp;
    repeat (8) cycle(4'b0000);
    check("t5_no_stale_rsp", 32'(n_rsp - rsp_mark), 32'd0);

`ifdef MULT_ARB_STATS_EN
    // Test 6: grant counters.
    apply_reset();
    arb_en    = 1'b1;
    req_valid = 4'b0100;
    x_arr[2]  = 4'd7;
    y_arr[2]  = 4'd9;
    repeat (20) cycle(4'b0100);
    req_valid = '0;
    repeat (6) cycle(4'b0000);
    for (int i = 0; i < NUM_REQ; i++)
      check("t6_stat_cnt", 32'(stat_cnt[i*16 +: 16]), (i == 2) ? 32'd20 : 32'd0);
`endif

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
